// File: rtl/axi_mw_pkg.sv
// Shared definitions for the AXI4 write master: burst and response encodings,
// the AW and W state machine encodings, and the fixed AWCACHE attribute.
package axi_mw_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Bufferable, modifiable, non-allocating.
  localparam logic [3:0] AWCACHE_DEFAULT = 4'b0011;

  typedef enum logic [1:0] {
    AW_IDLE = 2'd0,
    AW_SEND = 2'd1,
    AW_DONE = 2'd2
  } aw_state_t;

  typedef enum logic {
    W_IDLE   = 1'b0,
    W_ACTIVE = 1'b1
  } w_state_t;

endpackage

// File: rtl/axi_mw_wskid.sv
// W-channel holding register for the AXI write master.
// A burst is armed by start/start_len; local beats are then accepted into a
// one-entry register that drives the AXI W channel, with WLAST raised on the
// beat whose index equals the armed length.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, start_len    arm a burst of start_len+1 beats (only while idle)
//   wr_valid/wr_ready   local beat handshake, wr_data/wr_strb payload
//   wvalid/wready       AXI W handshake, wdata/wstrb/wlast payload
//   w_done              pulse on the WLAST handshake
//   w_state             current W state
// Handshakes: a transfer happens on any cycle where valid and ready are both
// high at the rising edge; a valid side never drops or changes payload while
// waiting for ready.
module axi_mw_wskid
  import axi_mw_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            start_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_strb,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  output logic                  w_done,
  output w_state_t              w_state
);

  w_state_t              state_q, state_d;
  logic [7:0]            tx_len_q, tx_len_d;
  logic [8:0]            beat_cnt_q, beat_cnt_d;
  logic                  wvalid_q, wvalid_d;
  logic                  wlast_q, wlast_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic                  load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= W_IDLE;
      tx_len_q   <= '0;
      beat_cnt_q <= '0;
      wvalid_q   <= 1'b0;
      wlast_q    <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      state_q    <= state_d;
      tx_len_q   <= tx_len_d;
      beat_cnt_q <= beat_cnt_d;
      wvalid_q   <= wvalid_d;
      wlast_q    <= wlast_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      W_IDLE:   if (start)  state_d = W_ACTIVE;
      W_ACTIVE: if (w_done) state_d = W_IDLE;
      default:  state_d = W_IDLE;
    endcase
  end

  always_comb begin
    // beat_cnt counts beats loaded so far; once it passes tx_len the burst
    // has all its beats and the local stream is refused.
    wr_ready = (state_q == W_ACTIVE) & (~wvalid_q | wready) &
               (beat_cnt_q <= {1'b0, tx_len_q});
    load     = wr_valid & wr_ready;
    w_done   = wvalid_q & wready & wlast_q;

    tx_len_d   = tx_len_q;
    beat_cnt_d = beat_cnt_q;
    wvalid_d   = wvalid_q;
    wlast_d    = wlast_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;

    if (start) begin
      tx_len_d   = start_len;
      beat_cnt_d = '0;
    end

    if (load) begin
      wvalid_d   = 1'b1;
      wdata_d    = wr_data;
      wstrb_d    = wr_strb;
      wlast_d    = (beat_cnt_q == {1'b0, tx_len_q});
      beat_cnt_d = beat_cnt_q + 9'd1;
    end else if (wvalid_q && wready) begin
      wvalid_d = 1'b0;
      wlast_d  = 1'b0;
    end

    wvalid  = wvalid_q;
    wlast   = wlast_q;
    wdata   = wdata_q;
    wstrb   = wstrb_q;
    w_state = state_q;
  end

endmodule

// File: rtl/axi_master_write_engine.sv
// AXI4 write master: turns a local burst request plus a local beat stream into
// AW/W traffic, tracks bursts awaiting B, and hands each B response back to the
// requester through a one-entry response buffer.
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   req_*                      burst request (addr, len=beats-1, size, burst)
//   wr_*                       local write beat stream
//   resp_*                     B response to the requester (code, BID error)
//   m_axi_aw*/w*/b*            AXI4 master write channels
//   outstanding                bursts issued and still awaiting B
// Handshakes: a transfer happens on any cycle where valid and ready are both
// high at the rising edge; a valid side never drops or changes payload while
// waiting for ready.
module axi_master_write_engine
  import axi_mw_pkg::*;
#(
  parameter int unsigned DATA_W          = 64,
  parameter int unsigned ADDR_W          = 32,
  parameter int unsigned ID_W            = 12,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned AXI_ID          = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [7:0]           req_len,
  input  logic [2:0]           req_size,
  input  logic [1:0]           req_burst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [DATA_W/8-1:0]  wr_strb,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [1:0]           resp_code,
  output logic                 resp_err,
  output logic                 m_axi_awvalid,
  input  logic                 m_axi_awready,
  output logic [ID_W-1:0]      m_axi_awid,
  output logic [ADDR_W-1:0]    m_axi_awaddr,
  output logic [7:0]           m_axi_awlen,
  output logic [2:0]           m_axi_awsize,
  output logic [1:0]           m_axi_awburst,
  output logic                 m_axi_awlock,
  output logic [3:0]           m_axi_awcache,
  output logic [2:0]           m_axi_awprot,
  output logic [3:0]           m_axi_awqos,
  output logic                 m_axi_wvalid,
  input  logic                 m_axi_wready,
  output logic [DATA_W-1:0]    m_axi_wdata,
  output logic [DATA_W/8-1:0]  m_axi_wstrb,
  output logic                 m_axi_wlast,
  input  logic                 m_axi_bvalid,
  output logic                 m_axi_bready,
  input  logic [ID_W-1:0]      m_axi_bid,
  input  logic [1:0]           m_axi_bresp,
  output logic [3:0]           outstanding
);

  localparam logic [ID_W-1:0] AWID_C    = ID_W'(AXI_ID);
  localparam logic [3:0]      MAX_OUT_C = 4'(MAX_OUTSTANDING);

  aw_state_t           aw_state_q, aw_state_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [7:0]          awlen_q, awlen_d;
  logic [2:0]          awsize_q, awsize_d;
  logic [1:0]          awburst_q, awburst_d;
  logic                w_seen_q, w_seen_d;
  logic [3:0]          outstanding_q, outstanding_d;
  logic                resp_valid_q, resp_valid_d;
  logic [1:0]          resp_code_q, resp_code_d;
  logic                resp_err_q, resp_err_d;

  logic                req_accept, burst_done, b_hs, b_dec, w_done;
  w_state_t            w_state;

  axi_mw_wskid #(.DATA_W(DATA_W)) u_wskid (
    .clk       (clk),
    .rst       (rst),
    .start     (req_accept),
    .start_len (req_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .wvalid    (m_axi_wvalid),
    .wready    (m_axi_wready),
    .wdata     (m_axi_wdata),
    .wstrb     (m_axi_wstrb),
    .wlast     (m_axi_wlast),
    .w_done    (w_done),
    .w_state   (w_state)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_state_q    <= AW_IDLE;
      awaddr_q      <= '0;
      awlen_q       <= '0;
      awsize_q      <= '0;
      awburst_q     <= '0;
      w_seen_q      <= 1'b0;
      outstanding_q <= '0;
      resp_valid_q  <= 1'b0;
      resp_code_q   <= '0;
      resp_err_q    <= 1'b0;
    end else begin
      aw_state_q    <= aw_state_d;
      awaddr_q      <= awaddr_d;
      awlen_q       <= awlen_d;
      awsize_q      <= awsize_d;
      awburst_q     <= awburst_d;
      w_seen_q      <= w_seen_d;
      outstanding_q <= outstanding_d;
      resp_valid_q  <= resp_valid_d;
      resp_code_q   <= resp_code_d;
      resp_err_q    <= resp_err_d;
    end
  end

  // The W side may finish before or after AW; w_seen remembers an early WLAST
  // so AW_DONE can close the burst as soon as both halves are through.
  assign burst_done = (aw_state_q == AW_DONE) & (w_seen_q | w_done);

  always_comb begin
    aw_state_d = aw_state_q;
    case (aw_state_q)
      AW_IDLE: if (req_accept)    aw_state_d = AW_SEND;
      AW_SEND: if (m_axi_awready) aw_state_d = AW_DONE;
      AW_DONE: if (burst_done)    aw_state_d = AW_IDLE;
      default:                    aw_state_d = AW_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (aw_state_q == AW_IDLE) & (w_state == W_IDLE) &
                    (outstanding_q < MAX_OUT_C);
    req_accept    = req_valid & req_ready;
    m_axi_awvalid = (aw_state_q == AW_SEND);
    m_axi_bready  = ~resp_valid_q | resp_ready;
    b_hs          = m_axi_bvalid & m_axi_bready;
    // A B with nothing outstanding is still reported, but must not wrap.
    b_dec         = b_hs & (outstanding_q != 4'd0);

    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    awsize_d  = awsize_q;
    awburst_d = awburst_q;
    if (req_accept) begin
      awaddr_d  = req_addr;
      awlen_d   = req_len;
      awsize_d  = req_size;
      awburst_d = req_burst;
    end

    w_seen_d = w_seen_q;
    if (burst_done)  w_seen_d = 1'b0;
    else if (w_done) w_seen_d = 1'b1;

    outstanding_d = outstanding_q;
    case ({burst_done, b_dec})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase

    resp_valid_d = resp_valid_q;
    resp_code_d  = resp_code_q;
    resp_err_d   = resp_err_q;
    if (b_hs) begin
      resp_valid_d = 1'b1;
      resp_code_d  = m_axi_bresp;
      resp_err_d   = (m_axi_bid != AWID_C) | (outstanding_q == 4'd0);
    end else if (resp_ready) begin
      resp_valid_d = 1'b0;
    end

    m_axi_awid    = AWID_C;
    m_axi_awaddr  = awaddr_q;
    m_axi_awlen   = awlen_q;
    m_axi_awsize  = awsize_q;
    m_axi_awburst = awburst_q;
    m_axi_awlock  = 1'b0;
    m_axi_awcache = AWCACHE_DEFAULT;
    m_axi_awprot  = 3'b000;
    m_axi_awqos   = 4'b0000;
    resp_valid    = resp_valid_q;
    resp_code     = resp_code_q;
    resp_err      = resp_err_q;
    outstanding   = outstanding_q;
  end

endmodule

// File: tb/tb_axi_master_write_engine.sv
// Directed and randomized bench for axi_master_write_engine. Expected AW
// payloads, W beats and responses are queued by the drivers from the values
// they send; negedge monitors pop and compare every observed handshake.
module tb_axi_master_write_engine;
  import axi_mw_pkg::*;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 32;
  localparam int ID_W   = 12;
  localparam int MAXO   = 4;
  localparam int STRB_W = DATA_W / 8;
  localparam int AWW    = ADDR_W + 8 + 3 + 2;
  localparam int WW     = 1 + STRB_W + DATA_W;
  localparam int LIMIT  = 300;

  logic clk, rst;
  logic req_valid, req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [7:0] req_len;
  logic [2:0] req_size;
  logic [1:0] req_burst;
  logic wr_valid, wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic [STRB_W-1:0] wr_strb;
  logic resp_valid, resp_ready, resp_err;
  logic [1:0] resp_code;
  logic awvalid, awready, awlock;
  logic [ID_W-1:0] awid;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0] awlen;
  logic [2:0] awsize, awprot;
  logic [1:0] awburst;
  logic [3:0] awcache, awqos;
  logic wvalid, wready, wlast;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic bvalid, bready;
  logic [ID_W-1:0] bid;
  logic [1:0] bresp;
  logic [3:0] outstanding;

  axi_master_write_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W),
    .MAX_OUTSTANDING(MAXO), .AXI_ID(0)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .req_size(req_size), .req_burst(req_burst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_strb(wr_strb),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_code(resp_code),
    .resp_err(resp_err),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awid(awid),
    .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
    .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bid(bid),
    .m_axi_bresp(bresp), .outstanding(outstanding)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [AWW-1:0] exp_aw_q[$];
  logic [WW-1:0]  exp_w_q[$];
  logic [2:0]     exp_resp_q[$];

  int n_cmp = 0;
  int n_fail = 0;
  int aw_hs_n = 0, wl_hs_n = 0, b_hs_n = 0, resp_n = 0;
  int stall_cnt = 0;
  int w_idx = 0, w_first = 0;
  int issued_tgt = 0;
  bit bubble_chk = 0;
  bit aw_pend = 0, w_pend = 0;
  logic [AWW-1:0] aw_prev;
  logic [WW-1:0]  w_prev;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outstanding count from the bench's view: bursts with both AW and WLAST
  // seen, minus B handshakes.
  function automatic int exp_out();
    int issued;
    issued = (aw_hs_n < wl_hs_n) ? aw_hs_n : wl_hs_n;
    return issued - b_hs_n;
  endfunction

  always @(negedge clk) begin
    logic [AWW-1:0] cur_aw;
    logic [WW-1:0]  cur_w;
    logic [AWW-1:0] ea;
    logic [WW-1:0]  ew;
    logic [2:0]     er;
    cur_aw = {awaddr, awlen, awsize, awburst};
    cur_w  = {wlast, wstrb, wdata};
    if (rst) begin
      aw_pend = 0; w_pend = 0; w_idx = 0;
      aw_hs_n = 0; wl_hs_n = 0; b_hs_n = 0;
    end else begin
      if (aw_pend) begin
        chk("aw_hold_valid", awvalid, 1'b1);
        chk("aw_hold_payload", cur_aw, aw_prev);
      end
      if (w_pend) begin
        chk("w_hold_valid", wvalid, 1'b1);
        chk("w_hold_payload", cur_w, w_prev);
      end
      if (awvalid && awready) begin
        aw_hs_n++;
        chk("aw_expected", exp_aw_q.size() != 0, 1'b1);
        if (exp_aw_q.size() != 0) begin
          ea = exp_aw_q.pop_front();
          chk("aw_payload", cur_aw, ea);
        end
        chk("aw_id", awid, 0);
        chk("aw_attr", {awlock, awcache, awprot, awqos}, {1'b0, AWCACHE_DEFAULT, 3'b000, 4'b0000});
      end
      if (wvalid && !wready) stall_cnt++;
      if (wvalid && wready) begin
        if (w_idx == 0) w_first = cyc;
        chk("w_expected", exp_w_q.size() != 0, 1'b1);
        if (exp_w_q.size() != 0) begin
          ew = exp_w_q.pop_front();
          chk("w_beat", cur_w, ew);
        end
        if (wlast) begin
          wl_hs_n++;
          if (bubble_chk) chk("w_zero_bubble", cyc - w_first, w_idx);
          w_idx = 0;
        end else begin
          w_idx++;
        end
      end
      if (bvalid && bready) b_hs_n++;
      if (resp_valid && resp_ready) begin
        resp_n++;
        chk("resp_expected", exp_resp_q.size() != 0, 1'b1);
        if (exp_resp_q.size() != 0) begin
          er = exp_resp_q.pop_front();
          chk("resp_payload", {resp_err, resp_code}, er);
        end
      end
      aw_pend = awvalid && !awready;
      aw_prev = cur_aw;
      w_pend  = wvalid && !wready;
      w_prev  = cur_w;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [ADDR_W-1:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [1:0] b);
    int t;
    t = 0;
    req_valid = 1'b1; req_addr = a; req_len = l; req_size = s; req_burst = b;
    @(negedge clk);
    while (!req_ready && t < LIMIT) begin @(negedge clk); t++; end
    chk("req_accept_wait", t < LIMIT, 1'b1);
    exp_aw_q.push_back({a, l, s, b});
    issued_tgt++;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s,
                           input logic last);
    int t;
    t = 0;
    exp_w_q.push_back({last, s, d});
    wr_valid = 1'b1; wr_data = d; wr_strb = s;
    @(negedge clk);
    while (!wr_ready && t < LIMIT) begin @(negedge clk); t++; end
    chk("wr_accept_wait", t < LIMIT, 1'b1);
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic send_burst(input logic [7:0] l);
    for (int i = 0; i <= int'(l); i++)
      send_beat({$urandom, $urandom}, 8'($urandom), i == int'(l));
  endtask

  task automatic send_b(input logic [ID_W-1:0] id, input logic [1:0] code);
    int t;
    t = 0;
    bvalid = 1'b1; bid = id; bresp = code;
    @(negedge clk);
    while (!bready && t < LIMIT) begin @(negedge clk); t++; end
    chk("b_accept_wait", t < LIMIT, 1'b1);
    exp_resp_q.push_back({id != ID_W'(0), code});
    tick();
    bvalid = 1'b0;
  endtask

  task automatic wait_issued(input int n);
    int t;
    t = 0;
    while ((aw_hs_n < n || wl_hs_n < n) && t < LIMIT) begin @(negedge clk); t++; end
    chk("issue_wait", t < LIMIT, 1'b1);
    repeat (2) tick();
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_resp_q.size() != 0 || exp_w_q.size() != 0 || exp_aw_q.size() != 0)
           && t < LIMIT) begin
      tick(); t++;
    end
    chk("drain_wait", t < LIMIT, 1'b1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_outstanding"}, outstanding, exp_out());
    chk({tag, "_req_ready"}, req_ready, exp_out() < MAXO);
  endtask

  // ---------------- directed + random sequence ----------------
  bit rand_done;
  int t_acc, t;
  int base_stall;
  logic [ADDR_W-1:0] a5;

  initial begin
    rst = 1'b1; req_valid = 0; req_addr = '0; req_len = '0; req_size = '0;
    req_burst = '0; wr_valid = 0; wr_data = '0; wr_strb = '0; resp_ready = 0;
    awready = 0; wready = 0; bvalid = 0; bid = '0; bresp = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_awvalid", awvalid, 1'b0);
    chk("rst_wvalid", wvalid, 1'b0);
    chk("rst_wlast", wlast, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_outstanding", outstanding, 4'd0);
    chk("rst_awpayload", {awaddr, awlen, awsize, awburst}, '0);
    chk("rst_wpayload", {wdata, wstrb}, '0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_bready", bready, 1'b1);
    rst = 1'b0;
    tick();

    // 4-beat burst, everything ready, zero-bubble streaming
    awready = 1; wready = 1; resp_ready = 1;
    bubble_chk = 1;
    send_req(32'h1000, 8'd3, 3'd3, BURST_INCR);
    send_burst(8'd3);
    wait_issued(issued_tgt);
    bubble_chk = 0;
    check_idle("t1");
    send_b(0, RESP_OKAY);
    wait_drain();

    // W stalled for 5 cycles while holding beat 2
    fork
      begin
        send_req($urandom, 8'd3, 3'd3, BURST_INCR);
        send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
        send_beat(64'hA5A5, 8'h0F, 1'b0);
        send_beat({$urandom, $urandom}, 8'hF0, 1'b0);
        send_beat({$urandom, $urandom}, 8'h3C, 1'b1);
      end
      begin
        t = 0;
        @(negedge clk);
        while (!(wvalid && wready) && t < LIMIT) begin @(negedge clk); t++; end
        chk("stall_trigger_wait", t < LIMIT, 1'b1);
        tick();
        wready = 0;
        base_stall = stall_cnt;
        repeat (5) tick();
        wready = 1;
      end
    join
    wait_issued(issued_tgt);
    chk("w_stall_cycles", stall_cnt - base_stall, 5);
    check_idle("t2");
    send_b(0, RESP_EXOKAY);
    wait_drain();

    // AW held off 10 cycles while W completes first
    awready = 0;
    send_req($urandom, 8'd1, 3'd2, BURST_WRAP);
    t_acc = cyc;
    send_burst(8'd1);
    t = 0;
    while (wl_hs_n < issued_tgt && t < LIMIT) begin tick(); t++; end
    chk("w_first_wait", t < LIMIT, 1'b1);
    repeat (2) tick();
    chk("aw_pending_valid", awvalid, 1'b1);
    chk("aw_pending_outstanding", outstanding, exp_out());
    while (cyc < t_acc + 10) tick();
    chk("aw_still_pending", awvalid, 1'b1);
    awready = 1;
    wait_issued(issued_tgt);
    check_idle("t3");
    send_b(0, RESP_OKAY);
    wait_drain();

    // Fill to MAX_OUTSTANDING with single-beat bursts, B withheld
    for (int i = 0; i < MAXO; i++) begin
      send_req($urandom, 8'd0, 3'd3, BURST_INCR);
      send_burst(8'd0);
    end
    wait_issued(issued_tgt);
    chk("full_outstanding", outstanding, exp_out());
    chk("full_req_ready", req_ready, exp_out() < MAXO);
    a5 = $urandom;
    req_valid = 1; req_addr = a5; req_len = 0; req_size = 3'd3; req_burst = BURST_INCR;
    repeat (3) begin
      @(negedge clk);
      chk("full_blocks_req", req_ready, 1'b0);
    end
    tick();
    send_b(0, 2'($urandom_range(0, 3)));
    send_req(a5, 8'd0, 3'd3, BURST_INCR);
    send_burst(8'd0);
    wait_issued(issued_tgt);
    check_idle("t4_refill");
    for (int i = 0; i < MAXO; i++) send_b(0, 2'($urandom_range(0, 3)));
    wait_drain();
    repeat (2) tick();
    check_idle("t4_empty");

    // Wrong BID with SLVERR, requester stalls the response 3 cycles
    send_req($urandom, 8'd0, 3'd1, BURST_FIXED);
    send_burst(8'd0);
    wait_issued(issued_tgt);
    resp_ready = 0;
    send_b(12'd5, RESP_SLVERR);
    repeat (3) begin
      @(negedge clk);
      chk("hold_resp_valid", resp_valid, 1'b1);
      chk("hold_resp_err", resp_err, 1'b1);
      chk("hold_resp_code", resp_code, RESP_SLVERR);
      chk("hold_bready", bready, 1'b0);
    end
    tick();
    resp_ready = 1;
    wait_drain();

    // Reset in the middle of a burst after beat 2
    send_req($urandom, 8'd3, 3'd3, BURST_INCR);
    send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    send_beat({$urandom, $urandom}, 8'hFF, 1'b0);
    wr_valid = 1; wr_data = {$urandom, $urandom};
    rst = 1;
    tick();
    rst = 0; wr_valid = 0;
    exp_aw_q.delete(); exp_w_q.delete(); exp_resp_q.delete();
    issued_tgt = 0;
    chk("mid_rst_awvalid", awvalid, 1'b0);
    chk("mid_rst_wvalid", wvalid, 1'b0);
    chk("mid_rst_resp_valid", resp_valid, 1'b0);
    chk("mid_rst_outstanding", outstanding, 4'd0);
    chk("mid_rst_req_ready", req_ready, 1'b1);
    repeat (5) tick();
    chk("post_rst_wvalid", wvalid, 1'b0);
    chk("post_rst_wr_ready", wr_ready, 1'b0);

    // Randomized bursts with random backpressure on every channel
    rand_done = 0;
    fork
      begin
        while (!rand_done) begin
          tick();
          awready    = 1'($urandom_range(0, 1));
          wready     = 1'($urandom_range(0, 1));
          resp_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int k = 0; k < 20; k++) begin
          logic [7:0] l;
          l = 8'($urandom_range(0, 7));
          send_req($urandom, l, 3'($urandom_range(0, 3)), 2'($urandom_range(0, 2)));
          send_burst(l);
          wait_issued(issued_tgt);
          send_b(($urandom_range(0, 3) == 0) ? 12'($urandom_range(1, 4095)) : 12'd0,
                 2'($urandom_range(0, 3)));
        end
        rand_done = 1;
      end
    join
    awready = 1; wready = 1; resp_ready = 1;
    wait_drain();
    repeat (3) tick();
    check_idle("final");
    chk("final_aw_q_empty", exp_aw_q.size(), 0);
    chk("final_w_q_empty", exp_w_q.size(), 0);
    chk("final_resp_q_empty", exp_resp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_master_write_engine.md
Name: axi_master_write_engine

Overview: Parametrised AXI4 write master. It converts a local burst request (address, length, size, burst type) plus a local write-data stream into AXI AW/W/B channel traffic, and returns the B response to the requester. It succeeds the single-beat W-channel holding model and adds full AW/W/B sequencing, beat counting with WLAST generation, and configurable data/ID width. It also supports up to MAX_OUTSTANDING bursts awaiting B. It sits between local DMA/datapath logic and the AXI interconnect.

Parameters:
DATA_W, 64, AXI data width in bits (multiple of 8); WSTRB width = DATA_W/8
ADDR_W, 32, address width
ID_W, 12, AWID/BID width
MAX_OUTSTANDING, 4, max bursts issued on AW whose B is not yet received (1..15)
AXI_ID, 0, constant AWID value

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  burst request valid
req_ready  out  1  request accepted when req_valid&req_ready
req_addr  in  ADDR_W  start address
req_len  in  8  beats-1 (AXI4 AWLEN encoding)
req_size  in  3  AWSIZE; must be <= log2(DATA_W/8)
req_burst  in  2  AWBURST
wr_valid  in  1  local write beat valid
wr_ready  out  1  local write beat accepted
wr_data  in  DATA_W  beat data
wr_strb  in  DATA_W/8  beat strobes
resp_valid  out  1  B response available
resp_ready  in  1  requester takes response
resp_code  out  2  BRESP
resp_err  out  1  BID mismatch flag
m_axi_awvalid/awready  out/in  1  AW handshake
m_axi_awid  out  ID_W  ; m_axi_awaddr out ADDR_W ; m_axi_awlen out 8 ; m_axi_awsize out 3 ; m_axi_awburst out 2
m_axi_awlock out 1 (0) ; m_axi_awcache out 4 (4'b0011) ; m_axi_awprot out 3 (0) ; m_axi_awqos out 4 (0)
m_axi_wvalid/wready  out/in  1  W handshake
m_axi_wdata  out  DATA_W ; m_axi_wstrb out DATA_W/8 ; m_axi_wlast out 1
m_axi_bvalid/bready  in/out  1  B handshake
m_axi_bid  in  ID_W ; m_axi_bresp in 2
outstanding  out  4  bursts awaiting B (debug)

Behaviour:
- Reset (sync, rst=1 at posedge): all valids 0, wlast 0, AW payload and wdata/wstrb registers 0, beat counter 0, outstanding 0, FSM AW_IDLE. rst mid-burst abandons the burst with no further AXI beats.
- req_ready = AW FSM in AW_IDLE & W FSM in W_IDLE & outstanding < MAX_OUTSTANDING.
- Request accept: register addr/len/size/burst into AW regs and latch len into tx_len. Next cycle awvalid=1 and the W FSM enters W_ACTIVE with beat_cnt=0.
- AW: awvalid stays high, payload stable, until awready. awvalid drops the cycle after the handshake. AW and W proceed independently; W may complete before AW.
- W skid register: when wvalid=0 or (wvalid&wready), the register loads from the local stream if wr_valid&W_ACTIVE. wr_ready = W_ACTIVE & (~wvalid | wready) & beats_loaded <= tx_len. While wvalid=1 & wready=0, wdata/wstrb/wlast hold exactly (AXI stability).
- wlast=1 on the beat where loaded index == tx_len. After the wlast handshake, W FSM returns to W_IDLE. Zero-bubble streaming: a new beat can hand off every cycle.
- Burst complete for issue = AW handshake done & wlast handshake done. Then outstanding +1.
- B: bready = ~resp_valid | resp_ready (one-entry response buffer). On bvalid&bready: resp_code=bresp, resp_err=(bid!=AXI_ID), resp_valid=1, outstanding -1.
- Same-cycle increment and decrement leave outstanding unchanged. B with outstanding==0 is a protocol error: the response is still captured and resp_err=1, and outstanding saturates at 0.
- FSM AW: AW_IDLE -> AW_SEND (accept) -> AW_DONE (awready) -> AW_IDLE (when burst complete). FSM W: W_IDLE -> W_ACTIVE -> W_IDLE (wlast handshake).
- req_len=0: single beat with wlast=1 on it.

Decomposition:
- Package axi_mw_pkg: BURST_FIXED/INCR/WRAP, RESP_OKAY/EXOKAY/SLVERR/DECERR, aw_state_t, w_state_t enums, AWCACHE default constant.
- Sub-module axi_mw_wskid: W-channel one-entry skid/holding register with beat counter and wlast generation.

Test Plan:
- req len=3 addr=0x1000, awready=1, wready=1, 4 beats streamed -> one AW (awlen=3), 4 W beats on consecutive cycles, wlast only on beat 4, bresp=OKAY -> resp_valid with resp_code=0.
- wready held low 5 cycles mid-burst (beat 2 = 0xA5A5) -> wdata/wstrb/wlast stable all 5 cycles, no beat lost or duplicated.
- awready delayed 10 cycles while W completes first -> W finishes, awvalid held with stable payload, outstanding increments only after awready.
- 5 back-to-back len=0 requests, MAX_OUTSTANDING=4, B withheld -> req_ready=0 after 4, outstanding=4; one B releases the 5th request.
- bid=5 with bresp=SLVERR and resp_ready=0 for 3 cycles -> resp_err=1, resp_code=2, bready=0 while buffer full.
- rst asserted mid-burst after beat 2 -> next cycle all valids 0, outstanding 0, req_ready=1.
